prio_arbiter_rr: RTL and testbench

- Parametrised successor to the combinational 4-input priority encoder.
- Arbitrates N request lines and registers a grant. Output is both one-hot and binary index.
- Mode select: fixed priority (highest index wins) or round-robin.
- A granted owner holds the grant until it finishes, drops its request, or exceeds a hold limit. Used in front of shared resources (UART tx, SRAM port, VGA overlay) by multiple clients.

---
 rtl/prio_arbiter_rr.sv | 90 +++++++++
 tb/tb_prio_arbiter_rr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: N-way request arbiter with registered one-hot/binary grant,
// fixed-priority or round-robin selection, and an optional per-grant hold limit.
module prio_arbiter_rr #(
   parameter int N        = 8,
   parameter int W        = 3,
   parameter int HOLD_MAX = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid,
   output logic         hold_expired
);
   localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
   typedef enum logic {IDLE, GRANT} state_t;
   state_t         state, state_nx;
   logic [CW-1:0]  hold_cnt, hold_cnt_nx;
   logic [W-1:0]   rr_ptr, rr_ptr_nx, sel_ptr, lo_idx, hi_idx, win_idx, gnt_idx_nx;
   logic [N-1:0]   gnt_nx;
   logic           lo_any, valid_nx, exp_nx, rel_drop, rel_exp;
   // Search downward from sel_ptr: prefer the highest request at or below it,
   // otherwise wrap to the highest request overall.
   always_comb begin
      sel_ptr = mode ? rr_ptr : W'(N-1);
      lo_any  = 1'b0;
      lo_idx  = '0;
      hi_idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && W'(i) <= sel_ptr) begin
            lo_any = 1'b1;
            lo_idx = W'(i);
         end
         if (req[i]) hi_idx = W'(i);
      end
      win_idx = lo_any ? lo_idx : hi_idx;
   end
   assign rel_drop = ~|(req & gnt);
   assign rel_exp  = HOLD_MAX > 0 && hold_cnt == CW'(HOLD_MAX - 1);
   always_comb begin
      state_nx    = state;
      gnt_nx      = gnt;
      gnt_idx_nx  = gnt_idx;
      valid_nx    = gnt_valid;
      exp_nx      = 1'b0;
      hold_cnt_nx = hold_cnt;
      rr_ptr_nx   = rr_ptr;
      if (state == IDLE) begin
         if (en && |req) begin
            state_nx    = GRANT;
            gnt_nx      = N'(1) << win_idx;
            gnt_idx_nx  = win_idx;
            valid_nx    = 1'b1;
            hold_cnt_nx = '0;
            rr_ptr_nx   = win_idx == '0 ? W'(N-1) : win_idx - 1'b1;
         end
      end else if (done || rel_drop || rel_exp) begin
         state_nx   = IDLE;
         gnt_nx     = '0;
         gnt_idx_nx = '0;
         valid_nx   = 1'b0;
         exp_nx     = !done && !rel_drop;
      end else if (HOLD_MAX > 0) begin
         hold_cnt_nx = hold_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         gnt          <= '0;
         gnt_idx      <= '0;
         gnt_valid    <= 1'b0;
         hold_expired <= 1'b0;
         hold_cnt     <= '0;
         rr_ptr       <= W'(N-1);
      end else begin
         state        <= state_nx;
         gnt          <= gnt_nx;
         gnt_idx      <= gnt_idx_nx;
         gnt_valid    <= valid_nx;
         hold_expired <= exp_nx;
         hold_cnt     <= hold_cnt_nx;
         rr_ptr       <= rr_ptr_nx;
      end
   end
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb_prio_arbiter_rr: directed checks of prio_arbiter_rr with N=8, HOLD_MAX=4.
module tb_prio_arbiter_rr;
   logic       clk = 1'b0, reset = 1'b1, en = 1'b0, mode = 1'b0, done = 1'b0;
   logic [7:0] req = '0, gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid, hold_expired;
   int         n_chk = 0, n_fail = 0;

   prio_arbiter_rr #(.N(8), .W(3), .HOLD_MAX(4)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .hold_expired(hold_expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic v);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
      check({tag, ".valid"}, 32'(gnt_valid), 32'(v));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cyc();
      cyc();
      reset = 1'b0;
      chk_gnt("reset", 8'h00, 3'd0, 1'b0);
      check("reset.exp", 32'(hold_expired), 0);

      // fixed priority
      en = 1'b1; mode = 1'b0; req = 8'b0101_0010;
      cyc();
      chk_gnt("fixed", 8'h40, 3'd6, 1'b1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_gnt("fixed.bubble", 8'h00, 3'd0, 1'b0);
      cyc();
      chk_gnt("fixed.regrant", 8'h40, 3'd6, 1'b1);
      req = 8'h00;
      cyc();
      chk_gnt("fixed.drop", 8'h00, 3'd0, 1'b0);
      check("fixed.drop.exp", 32'(hold_expired), 0);
      cyc();
      chk_gnt("idle.quiet", 8'h00, 3'd0, 1'b0);

      // round robin from rr_ptr = 7
      do_reset();
      mode = 1'b1; req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk_gnt($sformatf("rr%0d", k), 8'h01 << ((7 - k) & 7), 3'((7 - k) & 7), 1'b1);
         done = 1'b1;
         cyc();
         done = 1'b0;
         check($sformatf("rr%0d.bubble", k), 32'(gnt_valid), 0);
      end
      req = 8'h00;
      cyc();

      // hold limit
      do_reset();
      mode = 1'b0; req = 8'h01;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk_gnt($sformatf("hold%0d", k), 8'h01, 3'd0, 1'b1);
         check($sformatf("hold%0d.exp", k), 32'(hold_expired), 0);
      end
      cyc();
      chk_gnt("hold.expire", 8'h00, 3'd0, 1'b0);
      check("hold.expire.exp", 32'(hold_expired), 1);
      cyc();
      chk_gnt("hold.regrant", 8'h01, 3'd0, 1'b1);
      check("hold.regrant.exp", 32'(hold_expired), 0);

      // done coincident with expiry
      cyc();
      cyc();
      cyc();
      check("sim.still", 32'(gnt_valid), 1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_gnt("sim.release", 8'h00, 3'd0, 1'b0);
      check("sim.exp", 32'(hold_expired), 0);

      // owner drop
      req = 8'h08;
      cyc();
      chk_gnt("drop.grant", 8'h08, 3'd3, 1'b1);
      req = 8'h00;
      cyc();
      chk_gnt("drop.release", 8'h00, 3'd0, 1'b0);
      check("drop.exp", 32'(hold_expired), 0);

      // enable gating
      en = 1'b0; req = 8'h10;
      cyc();
      cyc();
      check("en0.none", 32'(gnt_valid), 0);
      en = 1'b1;
      cyc();
      chk_gnt("en1.grant", 8'h10, 3'd4, 1'b1);
      en = 1'b0;
      cyc();
      cyc();
      chk_gnt("en0.persist", 8'h10, 3'd4, 1'b1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_gnt("en0.done", 8'h00, 3'd0, 1'b0);
      cyc();
      check("en0.blocked", 32'(gnt_valid), 0);

      // async reset mid-grant
      en = 1'b1; req = 8'h20;
      cyc();
      chk_gnt("pre_rst", 8'h20, 3'd5, 1'b1);
      #2 reset = 1'b1;
      #1 chk_gnt("async_rst", 8'h00, 3'd0, 1'b0);
      req = 8'h00;
      cyc();
      reset = 1'b0;
      cyc();
      chk_gnt("post_rst", 8'h00, 3'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
